boom_ras_stack: RTL and testbench
=================================

// Module: boom_ras_stack
// PURPOSE
// - Parametrised return-address stack for the BOOM front end: a circular stack with push, pop,
//   replace, overflow wrap, empty tracking and checkpoint restore.
// - Sits beside the branch predictor. Pushes come from calls and pops from returns.
// - Restore repairs the pointer and count after a misprediction.
// - io_top_addr is registered and has write-through bypass.
// PARAMETERS
// - DEPTH   32  number of entries; power of two, >= 2
// - ADDR_W  40  return-address width
// - PTR_W   $clog2(DEPTH)  pointer width; derived, not overridable
// PORTS
// - clock              in   1           sole clock; all state on posedge
// - reset              in   1           asynchronous, active-low reset
// - io_push_valid      in   1           push io_push_addr (call)
// - io_push_addr       in   ADDR_W      address to push
// - io_pop_valid       in   1           pop top entry (return)
// - io_restore_valid   in   1           restore pointer and count from a checkpoint
// - io_restore_ptr     in   PTR_W       checkpointed top-of-stack pointer
// - io_restore_count   in   PTR_W+1     checkpointed occupancy
// - io_tos_ptr         out  PTR_W       current pointer, for checkpointing
// - io_count           out  PTR_W+1     occupancy, 0..DEPTH
// - io_top_addr        out  ADDR_W      registered top entry, valid the cycle after an update
// - io_empty           out  1           io_count == 0
// - io_overflow        out  1           1-cycle pulse: push while full, oldest entry lost
// - io_underflow       out  1           1-cycle pulse: pop while empty, pop ignored
// BEHAVIOUR
// - State: tos (PTR_W), count (PTR_W+1), ras[DEPTH] of ADDR_W.
// - ras is not reset. On reset assertion: tos=0, count=0, io_top_addr=0, pulses=0.
//   Reset assertion mid-operation discards any in-flight update.
// - Operation priority each cycle: restore > push&pop > push > pop.
//   - Restore: tos<=io_restore_ptr; count<=min(io_restore_count,DEPTH). Push and pop are ignored.
//   - Push only: tos<=tos+1 (mod DEPTH, wraps DEPTH-1->0); ras[tos+1]<=io_push_addr.
//     - count<=count+1, saturating at DEPTH.
//     - If full, count stays DEPTH, the oldest entry is overwritten and io_overflow=1.
//   - Pop only: if count>0 then tos<=tos-1 (mod DEPTH, wraps 0->DEPTH-1) and count<=count-1.
//     - If count==0, nothing changes and io_underflow=1.
//   - Push & pop (replace):
//     - If count>0, ras[tos]<=io_push_addr; tos and count are unchanged.
//     - If count==0, behave as push only.
// - Read latency is 1 cycle. io_top_addr is registered from the next-state top entry:
//   - It equals ras[tos_next] after this cycle's update.
//   - When this cycle writes ras[tos_next], io_top_addr takes io_push_addr (bypass, no stale value).
//   - After a restore, io_top_addr = ras[io_restore_ptr] as stored (entry contents are not repaired).
// - io_top_addr holds its value when no operation occurs. When count==0 its value is don't-care.
// - io_tos_ptr, io_count and io_empty come straight from registers.
// - All pointer arithmetic is modulo DEPTH. count is never > DEPTH and never negative.
// CONFIGURATION
// - BOOM_RAS_STATS_EN defined:
//   - Adds outputs io_ovf_cnt [15:0] and io_unf_cnt [15:0].
//   - Each counts io_overflow / io_underflow pulses, saturates at 16'hFFFF, and is reset to 0.
// - BOOM_RAS_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Reset, then push A=0x1000, B=0x2000 on consecutive cycles:
//   io_count=2, io_tos_ptr=2, and io_top_addr=0x2000 one cycle after the B push.
// - From {A,B}, pop:
//   next cycle io_top_addr=0x1000, io_count=1. Pop again -> io_empty=1.
//   A third pop -> io_underflow=1 for 1 cycle, count stays 0.
// - DEPTH=32, push 0x100+i for i=0..32 (33 pushes):
//   - On push 33: io_overflow=1 and io_count=32.
//   - Then 32 pops return 0x120 down to 0x101, and 0x100 is lost.
// - Replace: with top=0x2000, push&pop of 0x3000 ->
//   io_top_addr=0x3000 next cycle, io_count and io_tos_ptr unchanged.
// - Checkpoint and restore:
//   - Record tos=2/count=2, push 3 entries, then assert restore together with a push.
//   - Expect tos=2, count=2, io_top_addr=0x2000; the push is ignored.
// - With BOOM_RAS_STATS_EN: 3 underflows and 2 overflows -> io_unf_cnt=3, io_ovf_cnt=2.
//   Reset mid-stream -> both 0 and io_top_addr=0.

Source files
------------

// File: rtl/boom_ras_stack.sv
// boom_ras_stack: circular return-address stack with push, pop, replace, overflow wrap and checkpoint restore.
// Defining BOOM_RAS_STATS_EN adds saturating overflow/underflow event counters (io_ovf_cnt, io_unf_cnt).
module boom_ras_stack #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = 40,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_push_valid,
  input  logic [ADDR_W-1:0] io_push_addr,
  input  logic              io_pop_valid,
  input  logic              io_restore_valid,
  input  logic [PTR_W-1:0]  io_restore_ptr,
  input  logic [PTR_W:0]    io_restore_count,
  output logic [PTR_W-1:0]  io_tos_ptr,
  output logic [PTR_W:0]    io_count,
  output logic [ADDR_W-1:0] io_top_addr,
  output logic              io_empty,
  output logic              io_overflow,
  output logic              io_underflow
`ifdef BOOM_RAS_STATS_EN
  ,
  output logic [15:0]       io_ovf_cnt,
  output logic [15:0]       io_unf_cnt
`endif
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] ras_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, wr_idx;
  logic [PTR_W:0] count_q, count_d;
  logic [ADDR_W-1:0] top_q, top_d;
  logic ovf_q, ovf_d, unf_q, unf_d, wr_en;
  always_comb begin
    tos_d = tos_q;
    count_d = count_q;
    top_d = top_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    wr_en = 1'b0;
    wr_idx = tos_q;
    if (io_restore_valid) begin
      tos_d = io_restore_ptr;
      count_d = io_restore_count > FULL ? FULL : io_restore_count;
      top_d = ras_q[io_restore_ptr];
    end else if (io_push_valid && io_pop_valid && count_q != '0) begin
      wr_en = 1'b1;
      top_d = io_push_addr;
    end else if (io_push_valid) begin
      // a full stack wraps onto its oldest entry; the new top bypasses the array read
      tos_d = tos_q + 1'b1;
      wr_en = 1'b1;
      wr_idx = tos_q + 1'b1;
      ovf_d = count_q == FULL;
      count_d = count_q == FULL ? count_q : count_q + 1'b1;
      top_d = io_push_addr;
    end else if (io_pop_valid) begin
      unf_d = count_q == '0;
      tos_d = unf_d ? tos_q : tos_q - 1'b1;
      count_d = unf_d ? count_q : count_q - 1'b1;
      top_d = unf_d ? top_q : ras_q[tos_q - 1'b1];
    end
  end
  always_ff @(posedge clock)
    if (wr_en && reset) ras_q[wr_idx] <= io_push_addr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tos_q <= '0;
      count_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      count_q <= count_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign io_tos_ptr = tos_q;
  assign io_count = count_q;
  assign io_top_addr = top_q;
  assign io_empty = count_q == '0;
  assign io_overflow = ovf_q;
  assign io_underflow = unf_q;
`ifdef BOOM_RAS_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;
  always_comb begin
    ovf_cnt_d = ovf_cnt_q + {15'd0, ovf_d & ~&ovf_cnt_q};
    unf_cnt_d = unf_cnt_q + {15'd0, unf_d & ~&unf_cnt_q};
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  assign io_ovf_cnt = ovf_cnt_q;
  assign io_unf_cnt = unf_cnt_q;
`endif
endmodule

// File: tb/tb_boom_ras_stack.sv
// tb_boom_ras_stack: directed and randomized checks of boom_ras_stack against a circular-array reference model.
module tb_boom_ras_stack;
  localparam int DEPTH = 32;
  localparam int ADDR_W = 40;
  localparam int PTR_W = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_push_valid = 1'b0, io_pop_valid = 1'b0, io_restore_valid = 1'b0;
  logic [ADDR_W-1:0] io_push_addr = '0;
  logic [PTR_W-1:0] io_restore_ptr = '0;
  logic [PTR_W:0] io_restore_count = '0;
  logic [PTR_W-1:0] io_tos_ptr;
  logic [PTR_W:0] io_count;
  logic [ADDR_W-1:0] io_top_addr;
  logic io_empty, io_overflow, io_underflow;
`ifdef BOOM_RAS_STATS_EN
  logic [15:0] io_ovf_cnt, io_unf_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] mem [DEPTH];
  bit val [DEPTH];
  int m_tos = 0, m_cnt = 0, m_ovf_n = 0, m_unf_n = 0;
  bit m_ovf = 0, m_unf = 0;

  boom_ras_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .io_push_valid(io_push_valid), .io_push_addr(io_push_addr),
    .io_pop_valid(io_pop_valid), .io_restore_valid(io_restore_valid),
    .io_restore_ptr(io_restore_ptr), .io_restore_count(io_restore_count),
    .io_tos_ptr(io_tos_ptr), .io_count(io_count), .io_top_addr(io_top_addr),
    .io_empty(io_empty), .io_overflow(io_overflow), .io_underflow(io_underflow)
`ifdef BOOM_RAS_STATS_EN
    , .io_ovf_cnt(io_ovf_cnt), .io_unf_cnt(io_unf_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic drive(input logic p, input logic [ADDR_W-1:0] a, input logic po,
                       input logic r, input logic [PTR_W-1:0] rp, input logic [PTR_W:0] rc);
    io_push_valid = p; io_push_addr = a; io_pop_valid = po;
    io_restore_valid = r; io_restore_ptr = rp; io_restore_count = rc;
    m_ovf = 0; m_unf = 0;
    if (r) begin
      m_tos = int'(rp);
      m_cnt = int'(rc) > DEPTH ? DEPTH : int'(rc);
    end else if (p && po && m_cnt > 0) begin
      mem[m_tos] = a; val[m_tos] = 1;
    end else if (p) begin
      m_tos = (m_tos + 1) % DEPTH;
      mem[m_tos] = a; val[m_tos] = 1;
      m_ovf = m_cnt == DEPTH;
      if (m_cnt < DEPTH) m_cnt++;
    end else if (po) begin
      if (m_cnt == 0) m_unf = 1;
      else begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--; end
    end
    if (m_ovf && m_ovf_n < 65535) m_ovf_n++;
    if (m_unf && m_unf_n < 65535) m_unf_n++;
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a); drive(1, a, 0, 0, 0, 0); endtask
  task automatic pop(); drive(0, 0, 1, 0, 0, 0); endtask

  task automatic do_reset();
    io_push_valid = 0; io_pop_valid = 0; io_restore_valid = 0;
    reset = 1'b0;
    m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_ovf_n = 0; m_unf_n = 0;
    #2;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (io_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", io_count); end
    n_cmp++; if (io_tos_ptr !== 5'd0) begin n_err++; $display("FAIL reset_tos: got %0d want 0", io_tos_ptr); end
    n_cmp++; if (io_top_addr !== 40'd0) begin n_err++; $display("FAIL reset_top: got %h want 0", io_top_addr); end
    n_cmp++; if (io_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", io_empty); end
    n_cmp++; if ({io_overflow, io_underflow} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {io_overflow, io_underflow}); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_push_pop();
    do_reset();
    push(40'h1000);
    push(40'h2000);
    n_cmp++; if (io_count !== 6'd2) begin n_err++; $display("FAIL pp_count: got %0d want 2", io_count); end
    n_cmp++; if (io_tos_ptr !== 5'd2) begin n_err++; $display("FAIL pp_tos: got %0d want 2", io_tos_ptr); end
    n_cmp++; if (io_top_addr !== 40'h2000) begin n_err++; $display("FAIL pp_top_b: got %h want 2000", io_top_addr); end
    pop();
    n_cmp++; if (io_top_addr !== 40'h1000) begin n_err++; $display("FAIL pp_top_a: got %h want 1000", io_top_addr); end
    n_cmp++; if (io_count !== 6'd1) begin n_err++; $display("FAIL pp_count1: got %0d want 1", io_count); end
    pop();
    n_cmp++; if (io_empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %b want 1", io_empty); end
    pop();
    n_cmp++; if (io_underflow !== 1'b1) begin n_err++; $display("FAIL pp_underflow: got %b want 1", io_underflow); end
    n_cmp++; if (io_count !== 6'd0) begin n_err++; $display("FAIL pp_count0: got %0d want 0", io_count); end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (io_underflow !== 1'b0) begin n_err++; $display("FAIL pp_unf_pulse: got %b want 0", io_underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      push(40'h100 + ADDR_W'(i));
      n_cmp++; if (io_overflow !== (i == DEPTH)) begin n_err++; $display("FAIL ovf_pulse[%0d]: got %b want %b", i, io_overflow, i == DEPTH); end
    end
    n_cmp++; if (io_count !== 6'd32) begin n_err++; $display("FAIL ovf_count: got %0d want 32", io_count); end
    n_cmp++; if (io_tos_ptr !== 5'd1) begin n_err++; $display("FAIL ovf_tos_wrap: got %0d want 1", io_tos_ptr); end
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++; if (io_top_addr !== 40'h120 - ADDR_W'(k)) begin n_err++; $display("FAIL ovf_pop_top[%0d]: got %h want %h", k, io_top_addr, 40'h120 - ADDR_W'(k)); end
      pop();
    end
    n_cmp++; if (io_empty !== 1'b1 || io_underflow !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got empty=%b unf=%b want 1 0", io_empty, io_underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    push(40'h1000);
    push(40'h2000);
    drive(1, 40'h3000, 1, 0, 0, 0);
    n_cmp++; if (io_top_addr !== 40'h3000) begin n_err++; $display("FAIL repl_top: got %h want 3000", io_top_addr); end
    n_cmp++; if (io_count !== 6'd2 || io_tos_ptr !== 5'd2) begin n_err++; $display("FAIL repl_state: got cnt=%0d tos=%0d want 2 2", io_count, io_tos_ptr); end
    pop();
    n_cmp++; if (io_top_addr !== 40'h1000) begin n_err++; $display("FAIL repl_below: got %h want 1000", io_top_addr); end
  endtask

  task automatic test_restore();
    logic [PTR_W-1:0] ck_tos;
    logic [PTR_W:0] ck_cnt;
    do_reset();
    push(40'h1000);
    push(40'h2000);
    ck_tos = io_tos_ptr; ck_cnt = io_count;
    for (int i = 0; i < 3; i++) push(40'h5000 + ADDR_W'(i));
    drive(1, 40'hDEAD, 0, 1, ck_tos, ck_cnt);
    n_cmp++; if (io_tos_ptr !== 5'd2 || io_count !== 6'd2) begin n_err++; $display("FAIL rst_ckpt: got tos=%0d cnt=%0d want 2 2", io_tos_ptr, io_count); end
    n_cmp++; if (io_top_addr !== 40'h2000) begin n_err++; $display("FAIL rst_top: got %h want 2000", io_top_addr); end
    drive(0, 0, 0, 1, 5'd2, 6'd63);
    n_cmp++; if (io_count !== 6'd32) begin n_err++; $display("FAIL rst_clamp: got %0d want 32", io_count); end
  endtask

  task automatic test_stats();
`ifdef BOOM_RAS_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < DEPTH + 2; i++) push(40'h7000 + ADDR_W'(i));
    n_cmp++; if (io_unf_cnt !== 16'd3) begin n_err++; $display("FAIL stat_unf: got %0d want 3", io_unf_cnt); end
    n_cmp++; if (io_ovf_cnt !== 16'd2) begin n_err++; $display("FAIL stat_ovf: got %0d want 2", io_ovf_cnt); end
    io_push_valid = 1; io_push_addr = 40'hBEEF;
    reset = 1'b0;
    m_tos = 0; m_cnt = 0; m_ovf_n = 0; m_unf_n = 0;
    @(posedge clock); #1;
    n_cmp++; if (io_ovf_cnt !== 16'd0 || io_unf_cnt !== 16'd0) begin n_err++; $display("FAIL stat_reset: got %0d %0d want 0 0", io_ovf_cnt, io_unf_cnt); end
    n_cmp++; if (io_top_addr !== 40'd0 || io_count !== 6'd0) begin n_err++; $display("FAIL stat_reset_top: got %h cnt=%0d want 0 0", io_top_addr, io_count); end
    io_push_valid = 0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 4) drive(logic'($urandom_range(0, 1)), ADDR_W'({$urandom, $urandom}), 1'b0, 1'b1,
                         PTR_W'($urandom_range(0, DEPTH - 1)), (PTR_W+1)'($urandom_range(0, 40)));
      else if (sel < 45) drive(1, ADDR_W'({$urandom, $urandom}), 0, 0, 0, 0);
      else if (sel < 85) drive(0, 0, 1, 0, 0, 0);
      else if (sel < 93) drive(1, ADDR_W'({$urandom, $urandom}), 1, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (int'(io_tos_ptr) !== m_tos) begin n_err++; $display("FAIL rnd_tos[%0d]: got %0d want %0d", i, io_tos_ptr, m_tos); end
      n_cmp++; if (int'(io_count) !== m_cnt) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, io_count, m_cnt); end
      n_cmp++; if (io_empty !== (m_cnt == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, io_empty, m_cnt == 0); end
      n_cmp++; if (io_overflow !== m_ovf || io_underflow !== m_unf) begin n_err++; $display("FAIL rnd_pulses[%0d]: got %b%b want %b%b", i, io_overflow, io_underflow, m_ovf, m_unf); end
      if (m_cnt > 0 && val[m_tos]) begin
        n_cmp++; if (io_top_addr !== mem[m_tos]) begin n_err++; $display("FAIL rnd_top[%0d]: got %h want %h", i, io_top_addr, mem[m_tos]); end
      end
`ifdef BOOM_RAS_STATS_EN
      n_cmp++; if (int'(io_ovf_cnt) !== m_ovf_n || int'(io_unf_cnt) !== m_unf_n) begin n_err++; $display("FAIL rnd_stats[%0d]: got %0d %0d want %0d %0d", i, io_ovf_cnt, io_unf_cnt, m_ovf_n, m_unf_n); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_replace();
    test_restore();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
